// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider with start/done handshake.
// Define DIV_SIGNED_EN to add the is_signed port and two's-complement fix-up.
`timescale 1ns/1ps
module div_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
  localparam logic [WIDTH-1:0] ALL_ZERO  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] rem_r, dvd_r, dsr_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] quotient_r, remainder_r;
  logic             done_r, busy_r;

  logic             div0_s;
  logic [WIDTH-1:0] dvd_mag_s, dsr_mag_s;
  logic [WIDTH:0]   shift_s, diff_s;
  logic [WIDTH-1:0] rem_nx_s, dvd_nx_s;
  logic             q_bit_s;
  logic [WIDTH-1:0] q_fix_s, r_fix_s;

  assign div0_s = (divisor == ALL_ZERO);

`ifdef DIV_SIGNED_EN
  logic dvd_neg_s, dsr_neg_s;
  logic neg_q_r, neg_rm_r;

  assign dvd_neg_s = is_signed & dividend[WIDTH-1];
  assign dsr_neg_s = is_signed & divisor[WIDTH-1];
  assign dvd_mag_s = dvd_neg_s ? -dividend : dividend;
  assign dsr_mag_s = dsr_neg_s ? -divisor : divisor;
  // Quotient sign follows the operand sign mismatch; remainder follows the dividend.
  assign q_fix_s   = neg_q_r ? -dvd_nx_s : dvd_nx_s;
  assign r_fix_s   = neg_rm_r ? -rem_nx_s : rem_nx_s;

  // Sign flags captured with the operands on acceptance
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      neg_q_r  <= 1'b0;
      neg_rm_r <= 1'b0;
    end else if (start && (state_r != BUSY) && !div0_s) begin
      neg_q_r  <= dvd_neg_s ^ dsr_neg_s;
      neg_rm_r <= dvd_neg_s;
    end
  end
`else
  assign dvd_mag_s = dividend;
  assign dsr_mag_s = divisor;
  assign q_fix_s   = dvd_nx_s;
  assign r_fix_s   = rem_nx_s;
`endif

  // One restoring step; the borrow out of the WIDTH+1-bit subtract decides the quotient bit
  always_comb begin
    shift_s = {rem_r, dvd_r[WIDTH-1]};
    diff_s  = shift_s - {1'b0, dsr_r};
    if (!diff_s[WIDTH]) begin
      rem_nx_s = diff_s[WIDTH-1:0];
      q_bit_s  = 1'b1;
    end else begin
      rem_nx_s = shift_s[WIDTH-1:0];
      q_bit_s  = 1'b0;
    end
    dvd_nx_s = {dvd_r[WIDTH-2:0], q_bit_s};
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_s = div0_s ? DONE : BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == LAST_STEP) begin
          state_s = DONE;
        end else begin
          state_s = BUSY;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register and registered status flags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      done_r  <= (state_s == DONE);
      busy_r  <= (state_s == BUSY);
    end
  end

  // Datapath: operand capture, shift/subtract iteration and result registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rem_r       <= ALL_ZERO;
      dvd_r       <= ALL_ZERO;
      dsr_r       <= ALL_ZERO;
      cnt_r       <= {CNT_W{1'b0}};
      quotient_r  <= ALL_ZERO;
      remainder_r <= ALL_ZERO;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start && !div0_s) begin
            rem_r <= ALL_ZERO;
            dvd_r <= dvd_mag_s;
            dsr_r <= dsr_mag_s;
            cnt_r <= {CNT_W{1'b0}};
          end else if (start) begin
            quotient_r  <= ALL_ONES;
            remainder_r <= dividend;
          end
        end
        BUSY: begin
          rem_r <= rem_nx_s;
          dvd_r <= dvd_nx_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == LAST_STEP) begin
            quotient_r  <= q_fix_s;
            remainder_r <= r_fix_s;
          end
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign quotient  = quotient_r;
  assign remainder = remainder_r;
  assign done      = done_r;
  assign busy      = busy_r;

endmodule
